uart_frame_ctrl: RTL

//  Sequences the byte stream from uart_receiver into framed commands: SYNC, CMD, LEN, PAYLOAD[LEN], CHK.

---
 rtl/uart_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns the uart_receiver byte stream into framed commands
// (SYNC, CMD, LEN, PAYLOAD[LEN], CHK), buffers the payload and only releases
// it downstream once the XOR checksum has matched.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_HUNT    | idle, dropping bytes until SYNC_BYTE is seen
// S_CMD     | waiting for the command byte
// S_LEN     | waiting for the payload length byte
// S_PAYLOAD | storing payload bytes into the buffer
// S_CHK     | waiting for the checksum byte
// S_ACCEPT  | one cycle: frame_valid pulse, start of delivery
// S_DELIVER | streaming buffered payload to the downstream handshake
module uart_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         MAX_LEN       = 16,
   parameter int         TIMEOUT_TICKS = 640
) (
   input  logic       clk_50MHz,
   input  logic       reset,
   input  logic       sample_tick,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       frame_valid,
   output logic [7:0] frame_cmd,
   output logic [7:0] frame_len,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy,
   output logic       err_pulse,
   output logic [1:0] err_code,
   output logic [7:0] err_count
);

   localparam int PW    = $clog2(MAX_LEN + 1);
   localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DEPTH = 1 << AW;
   localparam int TW    = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [1:0] ERR_OVERRUN  = 2'd0;
   localparam logic [1:0] ERR_CHECKSUM = 2'd1;
   localparam logic [1:0] ERR_LENGTH   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [2:0] {
      S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_ACCEPT, S_DELIVER
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      chk_q, chk_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      len_q, len_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            frame_valid_q, frame_valid_d;
   logic [7:0]      frame_cmd_q, frame_cmd_d;
   logic [7:0]      frame_len_q, frame_len_d;
   logic            out_valid_q, out_valid_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic            busy_q, busy_d;
   logic            err_pulse_q, err_pulse_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [7:0]      err_count_q, err_count_d;

   logic            in_frame;
   logic            err_set;
   logic [1:0]      err_sel;
   logic            pbuf_we;
   logic [PW-1:0]   rd_nxt;
   logic [7:0]      pbuf_q [DEPTH];

   // Next-state, datapath and error bookkeeping for the frame sequencer
   always_comb begin
      state_d       = state_q;
      chk_d         = chk_q;
      timer_d       = timer_q;
      cmd_d         = cmd_q;
      len_d         = len_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      frame_valid_d = 1'b0;
      frame_cmd_d   = frame_cmd_q;
      frame_len_d   = frame_len_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_last_d    = out_last_q;
      err_pulse_d   = 1'b0;
      err_code_d    = err_code_q;
      err_count_d   = err_count_q;
      err_set       = 1'b0;
      err_sel       = ERR_OVERRUN;
      pbuf_we       = 1'b0;
      rd_nxt        = rd_ptr_q + PW'(1);
      in_frame      = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHK);

      // A byte always beats a coincident timeout tick
      if (in_frame) begin
         if (rx_ready) begin
            timer_d = '0;
         end else if (sample_tick) begin
            if (timer_q == TW'(TIMEOUT_TICKS - 1)) begin
               timer_d = '0;
               state_d = S_HUNT;
               err_set = 1'b1;
               err_sel = ERR_TIMEOUT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
      end

      case (state_q)
         S_HUNT: begin
            if (rx_ready && (rx_data == SYNC_BYTE)) begin
               state_d = S_CMD;
               chk_d   = 8'h00;
               timer_d = '0;
            end
         end
         S_CMD: begin
            if (rx_ready) begin
               cmd_d   = rx_data;
               chk_d   = chk_q ^ rx_data;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_ready) begin
               chk_d = chk_q ^ rx_data;
               if (rx_data > 8'(MAX_LEN)) begin
                  state_d = S_HUNT;
                  err_set = 1'b1;
                  err_sel = ERR_LENGTH;
               end else begin
                  len_d    = rx_data;
                  wr_ptr_d = '0;
                  state_d  = (rx_data == 8'h00) ? S_CHK : S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_ready) begin
               pbuf_we  = 1'b1;
               chk_d    = chk_q ^ rx_data;
               wr_ptr_d = wr_ptr_q + PW'(1);
               if ((8'(wr_ptr_q) + 8'd1) == len_q) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_ready) begin
               if (rx_data == chk_q) begin
                  state_d       = S_ACCEPT;
                  frame_valid_d = 1'b1;
                  frame_cmd_d   = cmd_q;
                  frame_len_d   = len_q;
               end else begin
                  state_d = S_HUNT;
                  err_set = 1'b1;
                  err_sel = ERR_CHECKSUM;
               end
            end
         end
         S_ACCEPT: begin
            rd_ptr_d = '0;
            if (len_q != 8'h00) begin
               state_d     = S_DELIVER;
               out_valid_d = 1'b1;
               out_data_d  = pbuf_q[0];
               out_last_d  = (len_q == 8'd1);
            end else begin
               state_d = S_HUNT;
            end
            if (rx_ready) begin
               err_set = 1'b1;
               err_sel = ERR_OVERRUN;
            end
         end
         S_DELIVER: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  state_d     = S_HUNT;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  rd_ptr_d   = rd_nxt;
                  out_data_d = pbuf_q[rd_nxt[AW-1:0]];
                  out_last_d = ((8'(rd_nxt) + 8'd1) == len_q);
               end
            end
            if (rx_ready) begin
               err_set = 1'b1;
               err_sel = ERR_OVERRUN;
            end
         end
         default: state_d = S_HUNT;
      endcase

      if (err_set) begin
         err_pulse_d = 1'b1;
         err_code_d  = err_sel;
         if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end

      busy_d = (state_d != S_HUNT);
   end

   // Register all state and outputs; reset discards any frame in flight
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         state_q       <= S_HUNT;
         chk_q         <= '0;
         timer_q       <= '0;
         cmd_q         <= '0;
         len_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         frame_valid_q <= 1'b0;
         frame_cmd_q   <= '0;
         frame_len_q   <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         busy_q        <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_code_q    <= '0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         chk_q         <= chk_d;
         timer_q       <= timer_d;
         cmd_q         <= cmd_d;
         len_q         <= len_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_valid_q <= frame_valid_d;
         frame_cmd_q   <= frame_cmd_d;
         frame_len_q   <= frame_len_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_last_q    <= out_last_d;
         busy_q        <= busy_d;
         err_pulse_q   <= err_pulse_d;
         err_code_q    <= err_code_d;
         err_count_q   <= err_count_d;
      end
   end

   // Payload storage; contents are only meaningful up to the accepted length
   always_ff @(posedge clk_50MHz) begin
      if (pbuf_we) pbuf_q[wr_ptr_q[AW-1:0]] <= rx_data;
   end

   assign frame_valid = frame_valid_q;
   assign frame_cmd   = frame_cmd_q;
   assign frame_len   = frame_len_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;
   assign busy        = busy_q;
   assign err_pulse   = err_pulse_q;
   assign err_code    = err_code_q;
   assign err_count   = err_count_q;

endmodule
